// File: rtl/frame_buffer_mp.sv
// Multi-port frame buffer: one VGA refresh read port plus NUM_PX user read/write ports,
// sharing a single-ported pixel RAM through a per-cycle priority/round-robin arbiter.
module frame_buffer_mp #(
    parameter int unsigned      PIX_W      = 24,
    parameter int unsigned      COL_BITS   = 8,
    parameter int unsigned      ROW_BITS   = 8,
    parameter int unsigned      NUM_PX     = 2,
    parameter logic [PIX_W-1:0] INIT_PIXEL = 24'h103f0f
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic [COL_BITS-1:0]         vc_col_address,
    input  logic [ROW_BITS-1:0]         vc_row_address,
    input  logic                        vc_request,
    output logic [PIX_W-1:0]            vc_read_data,
    output logic                        vc_read_valid,

    input  logic [NUM_PX*COL_BITS-1:0]  px_col_address,
    input  logic [NUM_PX*ROW_BITS-1:0]  px_row_address,
    input  logic [NUM_PX*PIX_W-1:0]     px_write_data,
    input  logic [NUM_PX*PIX_W/8-1:0]   px_write_mask,
    input  logic [NUM_PX-1:0]           px_request,
    input  logic [NUM_PX-1:0]           px_write,
    output logic [NUM_PX*PIX_W-1:0]     px_read_data,
    output logic [NUM_PX-1:0]           px_ready
);

    localparam int unsigned L     = PIX_W / 8;
    localparam int unsigned AW    = ROW_BITS + COL_BITS;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned PTR_W = (NUM_PX > 1) ? $clog2(NUM_PX) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StRdReady
    } port_state_e;

    // Per-port views of the packed input buses.
    logic [AW-1:0]    px_addr  [NUM_PX];
    logic [PIX_W-1:0] px_wdata [NUM_PX];
    logic [L-1:0]     px_mask  [NUM_PX];
    logic [PIX_W-1:0] px_rd_q  [NUM_PX];

    for (genvar g = 0; g < NUM_PX; g++) begin : g_port
        assign px_addr[g]  = {px_row_address[g*ROW_BITS +: ROW_BITS],
                              px_col_address[g*COL_BITS +: COL_BITS]};
        assign px_wdata[g] = px_write_data[g*PIX_W +: PIX_W];
        assign px_mask[g]  = px_write_mask[g*L +: L];
        assign px_read_data[g*PIX_W +: PIX_W] = px_rd_q[g];
    end

    port_state_e       state_q [NUM_PX];
    port_state_e       state_d [NUM_PX];
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM_PX-1:0] eligible;
    logic              grant_valid;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  cand;

    always_comb begin
        for (int i = 0; i < NUM_PX; i++) begin
            eligible[i] = px_request[i] && (state_q[i] == StIdle);
        end
    end

    // VGA has absolute priority; otherwise scan from rr_ptr upward, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (!vc_request) begin
            for (int unsigned k = 0; k < NUM_PX; k++) begin
                cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_PX);
                if (!grant_valid && eligible[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (32'(grant_idx) == NUM_PX - 1) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    // Shared RAM port: one address per cycle, lane-wise write enables.
    logic [AW-1:0]    ram_addr;
    logic [L-1:0]     ram_lane_we;
    logic [PIX_W-1:0] ram_wdata;
    logic [PIX_W-1:0] ram_q;

    always_comb begin
        ram_addr    = vc_request ? {vc_row_address, vc_col_address} : px_addr[grant_idx];
        ram_wdata   = px_wdata[grant_idx];
        ram_lane_we = '0;
        if (grant_valid && px_write[grant_idx]) begin
            ram_lane_we = px_mask[grant_idx];
        end
    end

    logic [PIX_W-1:0] mem [DEPTH] = '{default: INIT_PIXEL};

    always_ff @(posedge clk) begin
        for (int k = 0; k < L; k++) begin
            if (ram_lane_we[k]) begin
                mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
            end
        end
        ram_q <= mem[ram_addr];
    end

    always_comb begin
        for (int i = 0; i < NUM_PX; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (grant_valid && grant_idx == PTR_W'(i) && !px_write[i]) begin
                        state_d[i] = StRdWait;
                    end
                end
                StRdWait:  state_d[i] = StRdReady;
                StRdReady: state_d[i] = StIdle;
                default:   state_d[i] = StIdle;
            endcase
        end
    end

    // Writes complete in the grant cycle; reads complete two cycles later.
    always_comb begin
        for (int i = 0; i < NUM_PX; i++) begin
            px_ready[i] = (state_q[i] == StRdReady) ||
                          (grant_valid && grant_idx == PTR_W'(i) && px_write[i]);
        end
    end

    logic vc_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            vc_valid_q <= 1'b0;
            for (int i = 0; i < NUM_PX; i++) begin
                state_q[i] <= StIdle;
                px_rd_q[i] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            vc_valid_q <= vc_request;
            for (int i = 0; i < NUM_PX; i++) begin
                state_q[i] <= state_d[i];
                // ram_q holds the word fetched in the grant cycle.
                if (state_q[i] == StRdWait) begin
                    px_rd_q[i] <= ram_q;
                end
            end
        end
    end

    assign vc_read_valid = vc_valid_q;
    assign vc_read_data  = vc_valid_q ? ram_q : '0;

endmodule

// File: tb/tb_frame_buffer_mp.sv
// Self-checking bench for frame_buffer_mp: scoreboard of expected pixels against a
// behavioural memory model, checking latency, masking, arbitration and reset.
module tb_frame_buffer_mp;

    localparam int PIX_W    = 24;
    localparam int COL_BITS = 8;
    localparam int ROW_BITS = 8;
    localparam int NUM_PX   = 2;
    localparam int L        = PIX_W / 8;
    localparam logic [PIX_W-1:0] INIT = 24'h103f0f;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic [COL_BITS-1:0]        vc_col_address = '0;
    logic [ROW_BITS-1:0]        vc_row_address = '0;
    logic                       vc_request = 1'b0;
    logic [PIX_W-1:0]           vc_read_data;
    logic                       vc_read_valid;
    logic [NUM_PX*COL_BITS-1:0] px_col_address = '0;
    logic [NUM_PX*ROW_BITS-1:0] px_row_address = '0;
    logic [NUM_PX*PIX_W-1:0]    px_write_data = '0;
    logic [NUM_PX*L-1:0]        px_write_mask = '0;
    logic [NUM_PX-1:0]          px_request = '0;
    logic [NUM_PX-1:0]          px_write = '0;
    logic [NUM_PX*PIX_W-1:0]    px_read_data;
    logic [NUM_PX-1:0]          px_ready;

    frame_buffer_mp #(
        .PIX_W     (PIX_W),
        .COL_BITS  (COL_BITS),
        .ROW_BITS  (ROW_BITS),
        .NUM_PX    (NUM_PX),
        .INIT_PIXEL(INIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .vc_col_address(vc_col_address),
        .vc_row_address(vc_row_address),
        .vc_request    (vc_request),
        .vc_read_data  (vc_read_data),
        .vc_read_valid (vc_read_valid),
        .px_col_address(px_col_address),
        .px_row_address(px_row_address),
        .px_write_data (px_write_data),
        .px_write_mask (px_write_mask),
        .px_request    (px_request),
        .px_write      (px_write),
        .px_read_data  (px_read_data),
        .px_ready      (px_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [PIX_W-1:0] model [int];
    logic [PIX_W-1:0] exp_q [$];
    logic [PIX_W-1:0] vga_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] model_rd(input int a);
        return model.exists(a) ? model[a] : INIT;
    endfunction

    function automatic void model_wr(input int a, input logic [PIX_W-1:0] d, input logic [L-1:0] m);
        logic [PIX_W-1:0] w;
        w = model_rd(a);
        for (int k = 0; k < L; k++) begin
            if (m[k]) w[8*k +: 8] = d[8*k +: 8];
        end
        model[a] = w;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic set_port(input int p, input int row, input int col,
                            input logic [PIX_W-1:0] d, input logic [L-1:0] m, input logic wr);
        logic [7:0] r8, c8;
        r8 = row[7:0];
        c8 = col[7:0];
        px_row_address[p*ROW_BITS +: ROW_BITS] = r8;
        px_col_address[p*COL_BITS +: COL_BITS] = c8;
        px_write_data[p*PIX_W +: PIX_W]        = d;
        px_write_mask[p*L +: L]                = m;
        px_write[p]                            = wr;
    endtask

    task automatic do_write(input int p, input int row, input int col,
                            input logic [PIX_W-1:0] d, input logic [L-1:0] m);
        set_port(p, row, col, d, m, 1'b1);
        px_request[p] = 1'b1;
        @(negedge clk);
        check_eq("wr_ready", 32'(px_ready[p]), 1);
        model_wr(row * 256 + col, d, m);
        next_cycle();
        px_request[p] = 1'b0;
    endtask

    task automatic do_read(input int p, input int row, input int col);
        exp_q.push_back(model_rd(row * 256 + col));
        set_port(p, row, col, '0, '0, 1'b0);
        px_request[p] = 1'b1;
        @(negedge clk);
        check_eq("rd_t0_ready", 32'(px_ready[p]), 0);
        next_cycle();
        @(negedge clk);
        check_eq("rd_t1_ready", 32'(px_ready[p]), 0);
        next_cycle();
        @(negedge clk);
        check_eq("rd_t2_ready", 32'(px_ready[p]), 1);
        check_eq("rd_data", 32'(px_read_data[p*PIX_W +: PIX_W]), 32'(exp_q.pop_front()));
        next_cycle();
        px_request[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        apply_reset();
        @(negedge clk);
        check_eq("rst_vc_valid", 32'(vc_read_valid), 0);
        check_eq("rst_vc_data", 32'(vc_read_data), 0);
        check_eq("rst_px_ready", 32'(px_ready), 0);
        check_eq("rst_px_data", 32'(px_read_data[31:0]), 0);
        check_eq("rst_px_data_hi", 32'(px_read_data[47:32]), 0);

        // VGA read of (0,0) on fresh memory, then an idle cycle.
        next_cycle();
        vc_row_address = 8'd0;
        vc_col_address = 8'd0;
        vc_request     = 1'b1;
        vga_q.push_back(model_rd(0));
        next_cycle();
        vc_request = 1'b0;
        @(negedge clk);
        check_eq("vc_valid", 32'(vc_read_valid), 1);
        check_eq("vc_data", 32'(vc_read_data), 32'(vga_q.pop_front()));
        next_cycle();
        @(negedge clk);
        check_eq("vc_idle_valid", 32'(vc_read_valid), 0);
        check_eq("vc_idle_data", 32'(vc_read_data), 0);
        next_cycle();

        // Full write, read back; then partial and empty masks from port 1.
        do_write(0, 5, 7, 24'hAABBCC, 3'b111);
        do_read(0, 5, 7);
        do_write(1, 5, 7, 24'h112233, 3'b010);
        do_read(1, 5, 7);
        do_write(1, 5, 7, 24'hFFFFFF, 3'b000);
        do_read(0, 5, 7);
        // Read in the cycle right after a write to the same address.
        do_write(0, 9, 3, 24'h5A5A01, 3'b101);
        do_read(1, 9, 3);

        // VGA holds the RAM for 10 cycles while port 0 waits to read.
        set_port(0, 5, 7, '0, '0, 1'b0);
        px_request[0]  = 1'b1;
        vc_row_address = 8'd9;
        vc_col_address = 8'd3;
        vc_request     = 1'b1;
        for (int c = 0; c < 10; c++) begin
            vga_q.push_back(model_rd(9 * 256 + 3));
            @(negedge clk);
            check_eq("starve_ready", 32'(px_ready), 0);
            if (c > 0) begin
                check_eq("starve_vc_data", 32'(vc_read_data), 32'(vga_q.pop_front()));
            end
            next_cycle();
        end
        vc_request = 1'b0;
        do_read(0, 5, 7);
        vga_q.delete();

        // Reset while port 0 read is in its wait cycle.
        set_port(0, 5, 7, '0, '0, 1'b0);
        px_request[0] = 1'b1;
        @(negedge clk);
        check_eq("mid_t0_ready", 32'(px_ready[0]), 0);
        next_cycle();
        px_request[0] = 1'b0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("mid_rst_ready", 32'(px_ready), 0);
            next_cycle();
        end
        @(negedge clk);
        check_eq("mid_rst_data", 32'(px_read_data[23:0]), 0);
        next_cycle();
        do_write(0, 6, 6, 24'h0000EE, 3'b001);

        // Both ports write every cycle from reset: grants alternate 0,1,0,1.
        apply_reset();
        set_port(0, 1, 1, 24'h010101, 3'b111, 1'b1);
        set_port(1, 2, 2, 24'h020202, 3'b111, 1'b1);
        px_request = 2'b11;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("rr_grant", 32'(px_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
            next_cycle();
        end
        px_request = 2'b00;
        model_wr(1 * 256 + 1, 24'h010101, 3'b111);
        model_wr(2 * 256 + 2, 24'h020202, 3'b111);
        do_read(1, 1, 1);
        do_read(0, 2, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
